// File: rtl/sspwm_pkg.sv
// rtl/sspwm_pkg.sv - shared constants, FSM state codes and channel phase offsets
package sspwm_pkg;

  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 6;
  localparam int AMP_W   = 13;
  localparam int PEAK    = 5000;
  localparam int MI_FRAC = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // round(k * 2^pw / n) with integer arithmetic: (2*k*2^pw + n) / (2*n)
  function automatic longint ch_offset(int k, int n, int pw);
    return ((longint'(k) <<< (pw + 1)) + longint'(n)) / (longint'(2) * longint'(n));
  endfunction

endpackage

// File: rtl/sspwm_sine_gen_if.sv
// rtl/sspwm_sine_gen_if.sv - request and sample-set bundle of the sine generator
interface sspwm_sine_gen_if #(
  parameter int PHASE_W = 16,
  parameter int MI_W    = 9,
  parameter int AMP_W   = 13,
  parameter int N_CH    = 3
);
  logic                    sample_tick;
  logic [PHASE_W-1:0]      freq_word;
  logic [MI_W-1:0]         mod_index;
  logic                    phase_clr;
  logic                    busy;
  logic                    out_valid;
  logic                    overrun;
  logic [N_CH*AMP_W-1:0]   sine_mag;
  logic [N_CH-1:0]         sine_neg;

  modport master (
    output sample_tick, freq_word, mod_index, phase_clr,
    input  busy, out_valid, overrun, sine_mag, sine_neg
  );

  modport slave (
    input  sample_tick, freq_word, mod_index, phase_clr,
    output busy, out_valid, overrun, sine_mag, sine_neg
  );
endinterface

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - registered-read quarter-wave sine table
module sine_quarter_rom #(
  parameter int ADDR_W = 6,
  parameter int AMP_W  = 13,
  parameter int PEAK   = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   addr,
  output logic [AMP_W-1:0]  data
);

  // round(PEAK * sin(pi/2 * i / 2^ADDR_W)) via a Q30 Taylor series, so the
  // table elaborates from integers only
  function automatic longint rom_entry(int i);
    longint x, x2, term, sum;
    if (i >= (1 << ADDR_W)) return longint'(PEAK);
    x    = (longint'(1686629713) * longint'(i)) >>> ADDR_W;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return (longint'(PEAK) * sum + (longint'(1) <<< 29)) >>> 30;
  endfunction

  logic [AMP_W-1:0] tab [2**ADDR_W+1];

  for (genvar g = 0; g <= 2**ADDR_W; g++) begin : g_tab
    localparam logic [AMP_W-1:0] VAL = AMP_W'(rom_entry(g));
    assign tab[g] = VAL;
  end

  // one-cycle registered read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= tab[addr];
  end

endmodule

// File: rtl/sspwm_sine_gen.sv
// rtl/sspwm_sine_gen.sv - multi-channel sine reference generator with shared quarter-wave ROM
module sspwm_sine_gen #(
  parameter int PHASE_W = sspwm_pkg::PHASE_W,
  parameter int ADDR_W  = sspwm_pkg::ADDR_W,
  parameter int AMP_W   = sspwm_pkg::AMP_W,
  parameter int PEAK    = sspwm_pkg::PEAK,
  parameter int N_CH    = 3,
  parameter int MI_W    = 9,
  parameter int MI_FRAC = sspwm_pkg::MI_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  sspwm_sine_gen_if.slave   bus
);
  import sspwm_pkg::*;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int A1   = ADDR_W + 1;
  localparam int PW   = AMP_W + MI_W;

  logic [1:0]             state;
  logic [CH_W-1:0]        cnt;
  logic [PHASE_W-1:0]     phase_acc, ph_s;
  logic [MI_W-1:0]        mi_s;
  logic                   busy_q, overrun_q, out_valid_q;
  logic                   accept;

  logic [PHASE_W-1:0]     off_tab [N_CH];
  logic [ADDR_W+1:0]      p_top;
  logic [ADDR_W:0]        addr_nxt, addr_q;
  logic                   v1, neg1, v2, neg2, fin;
  logic [CH_W-1:0]        ch1, ch2;
  logic [AMP_W-1:0]       rom_q, sat;
  logic [PW-1:0]          s;
  logic [N_CH*AMP_W-1:0]  sh_mag, mag_q;
  logic [N_CH-1:0]        sh_neg, neg_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_off
    assign off_tab[g] = PHASE_W'(ch_offset(g, N_CH, PHASE_W));
  end

  assign accept   = bus.sample_tick && (state == ST_IDLE);
  // quadrant in the top two bits, ROM index below it; odd quadrants read mirrored
  assign p_top    = (ADDR_W+2)'((ph_s + off_tab[cnt]) >> (PHASE_W - 2 - ADDR_W));
  assign addr_nxt = p_top[ADDR_W] ? (A1'(2**ADDR_W) - {1'b0, p_top[ADDR_W-1:0]})
                                  : {1'b0, p_top[ADDR_W-1:0]};
  assign s        = PW'((PW'(rom_q) * PW'(mi_s)) >> MI_FRAC);
  assign sat      = (s > PW'(PEAK)) ? AMP_W'(PEAK) : s[AMP_W-1:0];

  // accept ticks, advance the phase and sequence channels through the ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      phase_acc <= '0;
      ph_s      <= '0;
      mi_s      <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.sample_tick && (state != ST_IDLE);
      if (bus.phase_clr) phase_acc <= '0;
      else if (accept)   phase_acc <= phase_acc + bus.freq_word;
      case (state)
        ST_IDLE: if (accept) begin
          ph_s   <= phase_acc;
          mi_s   <= bus.mod_index;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == CH_W'(N_CH - 1)) state <= ST_DRAIN;
          else                        cnt   <= cnt + 1'b1;
        end
        ST_DRAIN: if (fin) begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sine_quarter_rom #(.ADDR_W(ADDR_W), .AMP_W(AMP_W), .PEAK(PEAK)) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_q),
    .data  (rom_q)
  );

  // address, ROM and scaling stages tagged with channel and polarity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; ch1 <= '0; neg1 <= 1'b0; addr_q <= '0;
      v2 <= 1'b0; ch2 <= '0; neg2 <= 1'b0;
      sh_mag <= '0; sh_neg <= '0; fin <= 1'b0;
    end else begin
      v1     <= (state == ST_RUN);
      ch1    <= cnt;
      neg1   <= p_top[ADDR_W+1];
      addr_q <= addr_nxt;
      v2     <= v1;
      ch2    <= ch1;
      neg2   <= neg1;
      fin    <= v2 && (ch2 == CH_W'(N_CH - 1));
      if (v2) begin
        sh_mag[ch2*AMP_W +: AMP_W] <= sat;
        sh_neg[ch2]                <= neg2 && (sat != '0);
      end
    end
  end

  // publish the complete set in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      neg_q       <= '0;
    end else begin
      out_valid_q <= fin;
      if (fin) begin
        mag_q <= sh_mag;
        neg_q <= sh_neg;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.sine_mag  = mag_q;
  assign bus.sine_neg  = neg_q;

endmodule
